// File: rtl/ct_spsram_ctrl_pkg.sv
// Shared definitions for the 1024x128 single-port SRAM controller:
// geometry, response FIFO depth, FSM state type and the read-admission rule.
package ct_spsram_ctrl_pkg;

    localparam int ADDR_WIDTH = 10;
    localparam int DATA_WIDTH = 128;
    localparam int DEPTH      = 1024;
    localparam int RSP_DEPTH  = 2;
    localparam int RSP_CNT_W  = $clog2(RSP_DEPTH + 1);

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } ctrl_state_e;

    // A new read may issue only if every read already owed to the consumer
    // (stored in the FIFO or still inside the SRAM) still has a FIFO slot,
    // after crediting the entry that leaves the FIFO this cycle.
    function automatic logic rsp_has_room(input logic [RSP_CNT_W-1:0] cnt,
                                          input logic                 inflight,
                                          input logic                 pop);
        logic [RSP_CNT_W:0] occ;
        occ = {1'b0, cnt} + {{RSP_CNT_W{1'b0}}, inflight};
        return (occ - {{RSP_CNT_W{1'b0}}, pop}) < (RSP_CNT_W + 1)'(RSP_DEPTH);
    endfunction

endpackage

// File: rtl/ct_spsram_rsp_fifo.sv
// Small in-order response FIFO with valid/ready output and an occupancy count.
// Storage is not reset; only pointers and count are.
module ct_spsram_rsp_fifo
    import ct_spsram_ctrl_pkg::*;
#(
    parameter int WIDTH   = DATA_WIDTH,
    parameter int ENTRIES = RSP_DEPTH,
    parameter int CNT_W   = $clog2(ENTRIES + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    output logic             o_vld,
    input  logic             i_rdy,
    output logic [WIDTH-1:0] o_data,
    output logic [CNT_W-1:0] o_count
);

    localparam int PTR_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    logic [WIDTH-1:0] r_mem [ENTRIES];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic             w_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(ENTRIES - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign o_vld   = (r_count != '0);
    assign w_pop   = o_vld & i_rdy;
    assign o_data  = r_mem[r_rptr];
    assign o_count = r_count;

    // Pointer and occupancy bookkeeping; push+pop in one cycle keeps the count.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_wptr <= ptr_inc(r_wptr);
            end
            if (w_pop) begin
                r_rptr <= ptr_inc(r_rptr);
            end
            case ({i_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage, written at the tail.
    always_ff @(posedge i_clk) begin
        if (i_push) begin
            r_mem[r_wptr] <= i_push_data;
        end
    end

endmodule

// File: rtl/ct_spsram_1024x128_ctrl.sv
// Controller for a 1024x128 single-port SRAM: zero-fills the array after
// reset, then turns valid/ready requests into direct SRAM accesses and
// returns read data through a 2-entry response FIFO.
module ct_spsram_1024x128_ctrl #(
    parameter int ADDR_WIDTH = ct_spsram_ctrl_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = ct_spsram_ctrl_pkg::DATA_WIDTH,
    parameter int DEPTH      = ct_spsram_ctrl_pkg::DEPTH
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst,
    input  logic                  req_vld,
    output logic                  req_rdy,
    input  logic                  req_wr,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [DATA_WIDTH-1:0] req_wmask,
    output logic                  rsp_vld,
    input  logic                  rsp_rdy,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  init_done,
    output logic [ADDR_WIDTH-1:0] sram_a,
    output logic                  sram_cen,
    output logic                  sram_gwen,
    output logic [DATA_WIDTH-1:0] sram_wen,
    output logic [DATA_WIDTH-1:0] sram_d,
    input  logic [DATA_WIDTH-1:0] sram_q
);

    import ct_spsram_ctrl_pkg::*;

    ctrl_state_e           r_state;
    ctrl_state_e           w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_init_cnt;
    logic                  w_init_last;

    logic                  r_rd_vld_p1;
    logic                  w_run;
    logic                  w_pop;
    logic                  w_rd_room;
    logic                  w_acc;
    logic                  w_acc_rd;

    logic                  w_fifo_vld;
    logic [DATA_WIDTH-1:0] w_fifo_data;
    logic [RSP_CNT_W-1:0]  w_fifo_count;

    logic [ADDR_WIDTH-1:0] r_a_last;
    logic [DATA_WIDTH-1:0] r_d_last;
    logic [ADDR_WIDTH-1:0] w_sram_a;
    logic [DATA_WIDTH-1:0] w_sram_d;

    assign w_run       = (r_state == RUN);
    assign w_init_last = (r_init_cnt == ADDR_WIDTH'(DEPTH - 1));

    // Request handshake: writes only need RUN, reads also need a guaranteed
    // FIFO slot so that no returning SRAM data is ever dropped.
    assign w_pop     = w_fifo_vld & rsp_rdy;
    assign w_rd_room = rsp_has_room(w_fifo_count, r_rd_vld_p1, w_pop);
    assign req_rdy   = w_run & (req_wr | w_rd_room);
    assign w_acc     = req_vld & req_rdy;
    assign w_acc_rd  = w_acc & ~req_wr;

    assign init_done = w_run;
    assign sram_a    = w_sram_a;
    assign sram_d    = w_sram_d;
    assign rsp_vld   = w_fifo_vld;
    assign rsp_rdata = w_fifo_vld ? w_fifo_data : '0;

    // FSM state register; reset always restarts zero-fill.
    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            r_state <= INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state plus combinational SRAM drive for the current cycle.
    always_comb begin
        w_state_nxt = r_state;
        sram_cen    = 1'b1;
        sram_gwen   = 1'b1;
        sram_wen    = '1;
        w_sram_a    = r_a_last;
        w_sram_d    = r_d_last;
        case (r_state)
            INIT: begin
                if (!cpurst) begin
                    sram_cen  = 1'b0;
                    sram_gwen = 1'b0;
                    sram_wen  = '0;
                    w_sram_a  = r_init_cnt;
                    w_sram_d  = '0;
                    if (w_init_last) begin
                        w_state_nxt = RUN;
                    end
                end
            end
            RUN: begin
                if (w_acc) begin
                    sram_cen  = 1'b0;
                    sram_gwen = ~req_wr;
                    sram_wen  = req_wr ? ~req_wmask : '1;
                    w_sram_a  = req_addr;
                    w_sram_d  = req_wdata;
                end
            end
            default: begin
                w_state_nxt = INIT;
            end
        endcase
    end

    // Zero-fill address counter, advanced once per INIT cycle.
    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            r_init_cnt <= '0;
        end else if (r_state == INIT) begin
            r_init_cnt <= r_init_cnt + ADDR_WIDTH'(1);
        end
    end

    // Read issued last cycle: its SRAM data is on sram_q now and is pushed.
    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            r_rd_vld_p1 <= 1'b0;
        end else begin
            r_rd_vld_p1 <= w_acc_rd;
        end
    end

    // Address and data hold so idle cycles keep the SRAM pins stable.
    always_ff @(posedge forever_cpuclk) begin
        r_a_last <= w_sram_a;
        r_d_last <= w_sram_d;
    end

    ct_spsram_rsp_fifo #(
        .WIDTH   (DATA_WIDTH),
        .ENTRIES (RSP_DEPTH),
        .CNT_W   (RSP_CNT_W)
    ) u_rsp_fifo (
        .i_clk       (forever_cpuclk),
        .i_rst       (cpurst),
        .i_push      (r_rd_vld_p1),
        .i_push_data (sram_q),
        .o_vld       (w_fifo_vld),
        .i_rdy       (rsp_rdy),
        .o_data      (w_fifo_data),
        .o_count     (w_fifo_count)
    );

endmodule

// File: tb/tb_ct_spsram_1024x128_ctrl.sv
// Bench for ct_spsram_1024x128_ctrl: behavioural SRAM, a transaction-level
// reference model checked every cycle, and directed scenarios with literal
// expectations.
module tb_ct_spsram_1024x128_ctrl;

    localparam int AW  = 10;
    localparam int DW  = 128;
    localparam int DEP = 1024;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_vld;
    logic          req_rdy;
    logic          req_wr;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [DW-1:0] req_wmask;
    logic          rsp_vld;
    logic          rsp_rdy;
    logic [DW-1:0] rsp_rdata;
    logic          init_done;
    logic [AW-1:0] sram_a;
    logic          sram_cen;
    logic          sram_gwen;
    logic [DW-1:0] sram_wen;
    logic [DW-1:0] sram_d;
    logic [DW-1:0] sram_q;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ct_spsram_1024x128_ctrl dut (
        .forever_cpuclk (clk),
        .cpurst         (rst),
        .req_vld        (req_vld),
        .req_rdy        (req_rdy),
        .req_wr         (req_wr),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .req_wmask      (req_wmask),
        .rsp_vld        (rsp_vld),
        .rsp_rdy        (rsp_rdy),
        .rsp_rdata      (rsp_rdata),
        .init_done      (init_done),
        .sram_a         (sram_a),
        .sram_cen       (sram_cen),
        .sram_gwen      (sram_gwen),
        .sram_wen       (sram_wen),
        .sram_d         (sram_d),
        .sram_q         (sram_q)
    );

    // Behavioural single-port SRAM: write with active-low bit enables, or
    // read with data available in the following cycle.
    logic [DW-1:0] sram_mem [DEP];
    always @(posedge clk) begin
        if (!sram_cen) begin
            if (!sram_gwen) sram_mem[sram_a] <= (sram_mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
            else            sram_q <= sram_mem[sram_a];
        end
    end

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chkw(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Tracks memory contents, the list of owed read responses (with the cycle
    // each becomes visible) and the zero-fill progress.
    typedef struct packed {
        logic [DW-1:0] data;
        int            due;
    } rsp_t;

    rsp_t          exp_q[$];
    logic [DW-1:0] m_mem [DEP];
    int            m_cyc      = 0;
    int            m_init_idx = 0;
    bit            m_last_ok  = 1'b0;
    logic [AW-1:0] m_last_a;
    logic [DW-1:0] m_last_d;

    always @(negedge clk) begin
        logic          e_vld;
        logic          e_rdy;
        logic          e_acc;
        logic          e_pop;
        logic [DW-1:0] e_rdata;
        int            outst;
        rsp_t          ent;
        if (rst) begin
            chk1("m_rst_req_rdy", req_rdy, 1'b0);
            chk1("m_rst_rsp_vld", rsp_vld, 1'b0);
            chk1("m_rst_init_done", init_done, 1'b0);
            chk1("m_rst_cen", sram_cen, 1'b1);
            chk1("m_rst_gwen", sram_gwen, 1'b1);
            chkw("m_rst_wen", sram_wen, '1);
            chkw("m_rst_rdata", rsp_rdata, '0);
            exp_q.delete();
            m_init_idx = 0;
        end else if (m_init_idx < DEP) begin
            chk1("m_init_req_rdy", req_rdy, 1'b0);
            chk1("m_init_rsp_vld", rsp_vld, 1'b0);
            chk1("m_init_done", init_done, 1'b0);
            chk1("m_init_cen", sram_cen, 1'b0);
            chk1("m_init_gwen", sram_gwen, 1'b0);
            chkw("m_init_wen", sram_wen, '0);
            chkw("m_init_d", sram_d, '0);
            chkw("m_init_a", DW'(sram_a), DW'(m_init_idx));
            m_mem[m_init_idx] = '0;
            m_last_a   = AW'(m_init_idx);
            m_last_d   = '0;
            m_last_ok  = 1'b1;
            m_init_idx++;
        end else begin
            e_vld   = (exp_q.size() > 0) && (exp_q[0].due <= m_cyc);
            e_rdata = e_vld ? exp_q[0].data : '0;
            e_pop   = e_vld && rsp_rdy;
            outst   = exp_q.size();
            e_rdy   = req_wr || ((outst - (e_pop ? 1 : 0)) < 2);
            e_acc   = req_vld && e_rdy;
            chk1("m_run_init_done", init_done, 1'b1);
            chk1("m_req_rdy", req_rdy, e_rdy);
            chk1("m_rsp_vld", rsp_vld, e_vld);
            chkw("m_rsp_rdata", rsp_rdata, e_rdata);
            chk1("m_cen", sram_cen, !e_acc);
            chk1("m_gwen", sram_gwen, e_acc ? !req_wr : 1'b1);
            chkw("m_wen", sram_wen, (e_acc && req_wr) ? ~req_wmask : '1);
            if (e_acc) begin
                chkw("m_a", DW'(sram_a), DW'(req_addr));
                chkw("m_d", sram_d, req_wdata);
                m_last_a = req_addr;
                m_last_d = req_wdata;
            end else if (m_last_ok) begin
                chkw("m_a_hold", DW'(sram_a), DW'(m_last_a));
                chkw("m_d_hold", sram_d, m_last_d);
            end
            if (e_pop) void'(exp_q.pop_front());
            if (e_acc) begin
                if (req_wr) begin
                    m_mem[req_addr] = (m_mem[req_addr] & ~req_wmask) | (req_wdata & req_wmask);
                end else begin
                    ent.data = m_mem[req_addr];
                    ent.due  = m_cyc + 2;
                    exp_q.push_back(ent);
                end
            end
        end
        m_cyc++;
    end

    // ---------------- directed stimulus ----------------
    function automatic logic [DW-1:0] pat43(input int k);
        return {4{32'hC0DE_0000 + 32'(k)}};
    endfunction

    function automatic logic [DW-1:0] pat44(input int a);
        return {4{32'hA000_0000 + 32'(a)}};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW-1:0] m);
        req_vld = 1'b1; req_wr = 1'b1; req_addr = a; req_wdata = d; req_wmask = m;
        @(negedge clk);
        chk1("write_rdy", req_rdy, 1'b1);
        step();
        req_vld = 1'b0;
    endtask

    // Read accepted in cycle T, response visible exactly in T+2, popped there.
    task automatic do_read_check(input string name, input logic [AW-1:0] a, input logic [DW-1:0] exp);
        req_vld = 1'b1; req_wr = 1'b0; req_addr = a;
        @(negedge clk);
        chk1({name, "_rdy"}, req_rdy, 1'b1);
        step();
        req_vld = 1'b0;
        @(negedge clk);
        chk1({name, "_vld_t1"}, rsp_vld, 1'b0);
        step();
        @(negedge clk);
        chk1({name, "_vld_t2"}, rsp_vld, 1'b1);
        chkw({name, "_data"}, rsp_rdata, exp);
        step();
        @(negedge clk);
        chk1({name, "_vld_t3"}, rsp_vld, 1'b0);
        step();
    endtask

    // Counts the zero-fill writes after reset release; init_done must rise
    // in cycle 1025 exactly.
    task automatic check_init(input string name);
        int n_ok;
        n_ok = 0;
        for (int i = 1; i <= 1025; i++) begin
            @(negedge clk);
            if (i <= 1024) begin
                if (!sram_cen && !sram_gwen && sram_a == AW'(i - 1) && sram_wen == '0 && sram_d == '0) n_ok++;
                if (i == 1) chkw({name, "_first_addr"}, DW'(sram_a), DW'(0));
                if (i == 1024) chk1({name, "_done_1024"}, init_done, 1'b0);
            end else begin
                chk1({name, "_done_1025"}, init_done, 1'b1);
                chk1({name, "_rdy_1025"}, req_rdy, 1'b1);
            end
        end
        chki({name, "_writes"}, n_ok, 1024);
    endtask

    logic [DW-1:0] got[$];
    logic [DW-1:0] exp43 [4];
    logic [DW-1:0] first_data;
    int            n_acc;
    int            n_late_rdy;
    int            n_nrdy;
    int            n_rsp;
    int            n_bad;
    int            first_i;
    int            last_i;
    logic          acc;

    initial begin
        req_vld = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0; req_wmask = '0;
        rsp_rdy = 1'b0;
        exp43[0] = 128'hC0DE0001_C0DE0001_C0DE0001_C0DE0001;
        exp43[1] = 128'hC0DE0002_C0DE0002_C0DE0002_C0DE0002;
        exp43[2] = 128'hC0DE0003_C0DE0003_C0DE0003_C0DE0003;
        exp43[3] = 128'hC0DE0004_C0DE0004_C0DE0004_C0DE0004;

        repeat (3) @(posedge clk);
        #1;
        chk1("rst_req_rdy", req_rdy, 1'b0);
        chk1("rst_cen", sram_cen, 1'b1);
        chkw("rst_rdata", rsp_rdata, '0);
        rst = 1'b0;

        check_init("init1");
        step();

        // full-mask write then read of the same entry in the next cycle
        rsp_rdy = 1'b1;
        do_write(10'h155, {16{8'hA5}}, '1);
        do_read_check("r41", 10'h155, 128'hA5A5A5A5_A5A5A5A5_A5A5A5A5_A5A5A5A5);

        // partial mask into a zero-filled entry
        do_write(10'h3FF, '1, 128'h0000_FFFF);
        do_read_check("r42", 10'h3FF, 128'h00000000_00000000_00000000_0000FFFF);

        // back-pressure: only two reads may be owed while the consumer stalls
        for (int k = 1; k <= 4; k++) do_write(AW'(k), pat43(k), '1);
        rsp_rdy = 1'b0;
        n_acc = 0; n_late_rdy = 0;
        req_vld = 1'b1; req_wr = 1'b0; req_addr = AW'(1);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            acc = req_rdy;
            if (acc) n_acc++;
            if (c >= 2 && req_rdy) n_late_rdy++;
            step();
            if (acc) req_addr = req_addr + AW'(1);
        end
        chki("r43_accepted", n_acc, 2);
        chki("r43_rdy_after_full", n_late_rdy, 0);
        rsp_rdy = 1'b1;
        got.delete();
        for (int c = 0; c < 40 && got.size() < 4; c++) begin
            @(negedge clk);
            if (rsp_vld) got.push_back(rsp_rdata);
            acc = req_vld && req_rdy;
            step();
            if (acc) begin
                if (req_addr == AW'(4)) req_vld = 1'b0;
                else req_addr = req_addr + AW'(1);
            end
        end
        req_vld = 1'b0;
        chki("r43_resp_count", got.size(), 4);
        for (int k = 0; k < 4; k++) begin
            if (k < got.size()) chkw("r43_order", got[k], exp43[k]);
        end

        // streaming: 64 reads back-to-back, 64 responses in consecutive cycles
        for (int a = 0; a < 64; a++) do_write(AW'(a), pat44(a), '1);
        rsp_rdy = 1'b1;
        n_nrdy = 0; n_rsp = 0; n_bad = 0; first_i = -1; last_i = -1; first_data = '0;
        for (int i = 0; i < 70; i++) begin
            req_vld = (i < 64); req_wr = 1'b0; req_addr = AW'(i);
            @(negedge clk);
            if (i < 64 && !req_rdy) n_nrdy++;
            if (rsp_vld) begin
                if (first_i < 0) begin
                    first_i = i;
                    first_data = rsp_rdata;
                end
                last_i = i;
                if (rsp_rdata !== pat44(n_rsp)) n_bad++;
                n_rsp++;
            end
            step();
        end
        req_vld = 1'b0;
        chki("r44_not_ready", n_nrdy, 0);
        chki("r44_resp_count", n_rsp, 64);
        chki("r44_first_cycle", first_i, 2);
        chki("r44_last_cycle", last_i, 65);
        chki("r44_bad_data", n_bad, 0);
        chkw("r44_first_data", first_data, 128'hA0000000_A0000000_A0000000_A0000000);

        // reset with two responses parked in the FIFO
        rsp_rdy = 1'b0;
        req_vld = 1'b1; req_wr = 1'b0; req_addr = AW'(1);
        @(negedge clk);
        chk1("r45_rd1_rdy", req_rdy, 1'b1);
        step();
        req_addr = AW'(2);
        @(negedge clk);
        chk1("r45_rd2_rdy", req_rdy, 1'b1);
        step();
        req_vld = 1'b0;
        @(negedge clk);
        step();
        @(negedge clk);
        chk1("r45_full_vld", rsp_vld, 1'b1);
        step();
        rst = 1'b1;
        #1;
        chk1("r45_rst_vld", rsp_vld, 1'b0);
        chk1("r45_rst_rdy", req_rdy, 1'b0);
        chk1("r45_rst_cen", sram_cen, 1'b1);
        chkw("r45_rst_rdata", rsp_rdata, '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_init("init2");
        rsp_rdy = 1'b1;
        n_rsp = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (rsp_vld) n_rsp++;
            step();
        end
        chki("r45_no_stale", n_rsp, 0);
        do_read_check("r45_zeroed", AW'(1), '0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
